// File: rtl/sum_latch_uart_pkg.sv
// Shared definitions for the sum-latch UART transmitter: serialiser FSM states
// and the sizing helpers both the top and the byte serialiser depend on.
package sum_latch_uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } uart_state_e;

   // WIDTH is capped at 24, so the sum spans at most 4 bytes.
   localparam int MAX_NBYTES = 4;
   localparam int BYTE_IDX_W = 2;

   function automatic int nbytes(input int width);
      return (width + 1 + 7) / 8;
   endfunction

   function automatic int baud_w(input int clks_per_bit);
      return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. Valid/ready: a byte moves when i_valid && o_ready on a rising
// edge; o_ready is high in IDLE and in the final cycle of a stop bit, so bytes chain seamlessly.
module uart_byte_tx
   import sum_latch_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_valid,
   input  logic [7:0]                        i_data,
   output logic                              o_ready,
   output logic                              o_tx,
   output logic [1:0]                        o_state,
   output logic [baud_w(CLKS_PER_BIT)-1:0]   o_baud
);

   localparam int BAUD_W = baud_w(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   uart_state_e       r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_tx;
   logic              w_baud_end;
   logic              w_take;

   assign w_baud_end = (r_baud == BAUD_LAST);
   assign o_ready    = (r_state == IDLE) || ((r_state == STOP_BIT) && w_baud_end);
   assign w_take     = i_valid && o_ready;
   assign o_tx       = r_tx;
   assign o_state    = r_state;
   assign o_baud     = r_baud;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else if (w_take) begin
         r_state   <= START_BIT;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= i_data;
         r_tx      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_baud <= '0;
               r_tx   <= 1'b1;
            end
            START_BIT: begin
               if (w_baud_end) begin
                  r_state <= DATA_BITS;
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA_BITS: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state   <= STOP_BIT;
                     r_bit_idx <= '0;
                     r_tx      <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            STOP_BIT: begin
               // Reaching here at the end of the stop bit means no byte followed.
               if (w_baud_end) begin
                  r_state <= IDLE;
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_baud  <= '0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches a+b on an accepted start and sends it LSB byte first over 8N1 UART.
// busy drops and done pulses in the last cycle of the final stop bit, so a new start chains with no gap.
module sum_latch_uart_tx
   import sum_latch_uart_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 104
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic [WIDTH:0]   sum_q,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int NBYTES = nbytes(WIDTH);
   localparam int EXT_W  = NBYTES * 8;
   localparam int BAUD_W = baud_w(CLKS_PER_BIT);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NBYTES - 1);
   localparam logic [BAUD_W-1:0]     BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

   logic [WIDTH:0]          r_sum;
   logic [BYTE_IDX_W-1:0]   r_byte_idx;
   logic                    r_busy;
   logic                    r_done;

   logic [WIDTH:0]          w_sum_new;
   logic [EXT_W-1:0]        w_new_ext;
   logic [EXT_W-1:0]        w_sum_ext;
   logic [EXT_W-1:0]        w_src_ext;
   logic [2:0]              w_sel_idx;
   logic [7:0]              w_byte;
   logic                    w_accept;
   logic                    w_next;
   logic                    w_valid;
   logic                    w_ready;
   logic                    w_tx;
   logic [1:0]              w_state;
   logic [BAUD_W-1:0]       w_baud;
   logic                    w_stop_pre;
   logic                    w_final_pre;

   assign w_sum_new = {1'b0, a} + {1'b0, b};
   assign w_new_ext = EXT_W'(w_sum_new);
   assign w_sum_ext = EXT_W'(r_sum);

   assign w_accept = start && !r_busy;
   assign w_next   = r_busy && w_ready && (r_byte_idx != LAST_BYTE);
   assign w_valid  = w_accept || w_next;

   // One cycle before the stop bit's last cycle; on the final byte that is where busy/done flip.
   assign w_stop_pre  = (w_state == STOP_BIT) && (w_baud == BAUD_PRE);
   assign w_final_pre = r_busy && w_stop_pre && (r_byte_idx == LAST_BYTE);

   // The first byte comes straight from the adder so its start bit lands the cycle after accept.
   assign w_src_ext = w_accept ? w_new_ext : w_sum_ext;
   assign w_sel_idx = w_accept ? 3'd0 : ({1'b0, r_byte_idx} + 3'd1);

   always_comb begin
      w_byte = 8'h00;
      for (int k = 0; k < NBYTES; k++) begin
         if (w_sel_idx == 3'(k)) begin
            w_byte = w_src_ext[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum      <= '0;
         r_byte_idx <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_final_pre;
         if (w_accept) begin
            r_sum      <= w_sum_new;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
         end else begin
            if (w_next) begin
               r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_final_pre) begin
               r_busy <= 1'b0;
            end
         end
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid),
      .i_data  (w_byte),
      .o_ready (w_ready),
      .o_tx    (w_tx),
      .o_state (w_state),
      .o_baud  (w_baud)
   );

   assign sum_q = r_sum;
   assign tx    = w_tx;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Bench for sum_latch_uart_tx: one-byte (WIDTH=4) and two-byte (WIDTH=12) instances
// against a queue-of-line-bits model, plus literal checks of the documented frames.
module tb_sum_latch_uart_tx;

   localparam int CPB = 4;

   typedef bit bitq_t[$];

   logic        clk;
   logic        rst = 1'b1;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        start4 = 1'b0;
   logic [11:0] a12 = '0, b12 = '0;
   logic        start12 = 1'b0;
   logic [4:0]  sum4;
   logic [12:0] sum12;
   logic        tx4, busy4, done4, tx12, busy12, done12;

   int n_checks = 0;
   int n_errors = 0;

   // Model: every remaining line-bit cycle of the frame in progress, one entry per clock.
   bitq_t q4, q12;
   int    exp_sum4 = 0, exp_sum12 = 0;
   bit    cmp_en = 1'b0;

   bit    cap_bits[0:19];
   int    cap_done_cyc;

   sum_latch_uart_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .start(start4),
      .sum_q(sum4), .tx(tx4), .busy(busy4), .done(done4)
   );

   sum_latch_uart_tx #(.WIDTH(12), .CLKS_PER_BIT(CPB)) dut12 (
      .clk(clk), .rst(rst), .a(a12), .b(b12), .start(start12),
      .sum_q(sum12), .tx(tx12), .busy(busy12), .done(done12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bitq_t frame_bits(input int unsigned val, input int nb);
      bitq_t q;
      logic [9:0] fr;
      for (int j = 0; j < nb; j++) begin
         fr = {1'b1, 8'(val >> (8 * j)), 1'b0};
         for (int k = 0; k < 10; k++)
            for (int c = 0; c < CPB; c++)
               q.push_back(fr[k]);
      end
      return q;
   endfunction

   // Model update on each rising edge (or reset).
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q4.delete();
            q12.delete();
            exp_sum4  = 0;
            exp_sum12 = 0;
         end else begin
            if (start4 && q4.size() <= 1) begin
               exp_sum4 = int'(a4) + int'(b4);
               q4 = frame_bits(exp_sum4, 1);
            end else if (q4.size() > 0) begin
               void'(q4.pop_front());
            end
            if (start12 && q12.size() <= 1) begin
               exp_sum12 = int'(a12) + int'(b12);
               q12 = frame_bits(exp_sum12, 2);
            end else if (q12.size() > 0) begin
               void'(q12.pop_front());
            end
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("tx4",    tx4,    (q4.size() > 0) ? q4[0] : 1'b1);
            check("busy4",  busy4,  q4.size() > 1);
            check("done4",  done4,  q4.size() == 1);
            check("sum4",   sum4,   exp_sum4);
            check("tx12",   tx12,   (q12.size() > 0) ? q12[0] : 1'b1);
            check("busy12", busy12, q12.size() > 1);
            check("done12", done12, q12.size() == 1);
            check("sum12",  sum12,  exp_sum12);
         end
      end
   end

   // Launch a frame now (caller is at a negedge), capture mid-bit samples until done.
   task automatic run_frame(input bit sel, input logic [11:0] av, input logic [11:0] bv,
                            input int repulse_at);
      int cyc;
      logic t, d;
      if (sel) begin a12 = av; b12 = bv; start12 = 1'b1; end
      else     begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
      cap_done_cyc = -1;
      for (int i = 0; i < 20; i++) cap_bits[i] = 1'b0;
      cyc = 0;
      while (cyc < 400 && cap_done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == repulse_at) begin
            if (sel) begin a12 = 12'h123; b12 = 12'h045; start12 = 1'b1; end
            else     begin a4 = 4'd3; b4 = 4'd2; start4 = 1'b1; end
         end else begin
            start4  = 1'b0;
            start12 = 1'b0;
         end
         t = sel ? tx12 : tx4;
         d = sel ? done12 : done4;
         if ((cyc - 1) % CPB == CPB / 2 && (cyc - 1) / CPB < 20)
            cap_bits[(cyc - 1) / CPB] = t;
         if (d) cap_done_cyc = cyc;
      end
      start4  = 1'b0;
      start12 = 1'b0;
      check("done_timeout", (cap_done_cyc < 0) ? 32'd1 : 32'd0, 32'd0);
   endtask

   function automatic logic [9:0] slot_pattern(input int base);
      logic [9:0] p;
      for (int k = 0; k < 10; k++) p[k] = cap_bits[base + k];
      return p;
   endfunction

   function automatic logic [7:0] decode_byte(input int base);
      logic [7:0] v;
      for (int k = 0; k < 8; k++) v[k] = cap_bits[base + 1 + k];
      return v;
   endfunction

   initial begin
      int done_seen;
      repeat (3) @(negedge clk);
      check("rst_tx4",   tx4,   1'b1);
      check("rst_busy4", busy4, 1'b0);
      check("rst_done4", done4, 1'b0);
      check("rst_sum4",  sum4,  5'd0);
      check("rst_sum12", sum12, 13'd0);
      rst = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);

      // 9+8=17 -> 0x11 frame, done 40 cycles after the start cycle.
      run_frame(1'b0, 12'd9, 12'd8, 0);
      check("r031_sum",  sum4, 5'd17);
      check("r031_bits", slot_pattern(0), 10'h222);
      check("r031_byte", decode_byte(0), 8'h11);
      check("r031_done", cap_done_cyc, 40);

      // Start in the done cycle: 15+15=30 begins with no idle bit.
      run_frame(1'b0, 12'd15, 12'd15, 0);
      check("r032_sum",  sum4, 5'd30);
      check("r032_byte", decode_byte(0), 8'h1E);
      check("r036_startbit", cap_bits[0], 1'b0);
      check("r036_done", cap_done_cyc, 40);
      repeat (3) @(negedge clk);

      // Mid-frame re-pulse with other operands must change nothing.
      run_frame(1'b0, 12'd9, 12'd8, 15);
      check("r034_sum",  sum4, 5'd17);
      check("r034_bits", slot_pattern(0), 10'h222);
      check("r034_done", cap_done_cyc, 40);
      repeat (3) @(negedge clk);

      // Two-byte frame 4095+4095=8190.
      run_frame(1'b1, 12'd4095, 12'd4095, 0);
      check("r033_sum",   sum12, 13'd8190);
      check("r033_byte0", decode_byte(0), 8'hFE);
      check("r033_byte1", decode_byte(10), 8'h1F);
      check("r033_frame1", slot_pattern(10), {1'b1, 8'h1F, 1'b0});
      check("r033_done",  cap_done_cyc, 80);
      repeat (3) @(negedge clk);

      // Reset during data bit 3 (slot 4, cycles 17..20).
      a4 = 4'd9; b4 = 4'd8; start4 = 1'b1;
      repeat (18) begin
         @(negedge clk);
         start4 = 1'b0;
      end
      check("r035_busy_before", busy4, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("r035_tx",   tx4,   1'b1);
      check("r035_busy", busy4, 1'b0);
      check("r035_done", done4, 1'b0);
      check("r035_sum",  sum4,  5'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (done4 || !tx4) done_seen++;
      end
      check("r035_quiet", done_seen, 0);

      // Randomised phase with ignored starts, chained starts and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         a4      = 4'($urandom);
         b4      = 4'($urandom);
         start4  = ($urandom_range(0, 15) == 0);
         a12     = 12'($urandom);
         b12     = 12'($urandom);
         start12 = ($urandom_range(0, 20) == 0);
         if ($urandom_range(0, 999) == 0) begin
            start4  = 1'b0;
            start12 = 1'b0;
            #1 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      start4  = 1'b0;
      start12 = 1'b0;
      repeat (100) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
